// File: rtl/ex_operand_stage.sv
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX pipeline register with EX/MEM and MEM/WB operand
//               forwarding and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_alu_src,
  input  logic                  id_uses_rs2,
  input  logic [3:0]            id_alu_control,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     data1,
  output logic [DATA_W-1:0]     data2,
  output logic [3:0]            ALU_control,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  load_use_hazard
);

  localparam logic [REG_ADDR_W-1:0] c_x0 = '0;

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_rs1_data;
  logic [DATA_W-1:0]     r_rs2_data;
  logic [DATA_W-1:0]     r_imm;
  logic                  r_alu_src;
  logic [3:0]            r_alu_control;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;

  logic [DATA_W-1:0]     w_fwd_rs1;
  logic [DATA_W-1:0]     w_fwd_rs2;

  // A flush still captures the data fields; only the side-effecting controls
  // and the opcode are forced to the bubble value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= 4'b0000;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (flush || !stall) begin
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_alu_src  <= id_alu_src;
      if (flush) begin
        r_valid       <= 1'b0;
        r_alu_control <= 4'b0000;
        r_reg_write   <= 1'b0;
        r_mem_read    <= 1'b0;
        r_mem_write   <= 1'b0;
      end else begin
        r_valid       <= id_valid;
        r_alu_control <= id_alu_control;
        r_reg_write   <= id_reg_write;
        r_mem_read    <= id_mem_read;
        r_mem_write   <= id_mem_write;
      end
    end
  end

  // EX/MEM is checked first: it holds the younger write of the two.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [DATA_W-1:0]     rf_data,
    input logic                  em_we,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic [DATA_W-1:0]     em_res,
    input logic                  mw_we,
    input logic [REG_ADDR_W-1:0] mw_rd,
    input logic [DATA_W-1:0]     mw_res
  );
    if (em_we && (em_rd != c_x0) && (em_rd == rs))
      return em_res;
    else if (mw_we && (mw_rd != c_x0) && (mw_rd == rs))
      return mw_res;
    else
      return rf_data;
  endfunction

  always_comb begin
    w_fwd_rs1 = fwd_sel(r_rs1, r_rs1_data, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result);
    w_fwd_rs2 = fwd_sel(r_rs2, r_rs2_data, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result);
  end

  assign data1         = w_fwd_rs1;
  assign data2         = r_alu_src ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign ALU_control   = r_alu_control;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;

  assign load_use_hazard = r_valid && r_mem_read && (r_rd != c_x0) && id_valid &&
                           ((r_rd == id_rs1) || (id_uses_rs2 && (r_rd == id_rs2)));

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// ============================================================================
// Module      : tb_ex_operand_stage
// Description : Scoreboard bench for ex_operand_stage against a slot model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_operand_stage;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;

  typedef struct {
    logic                  reset, stall, flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0]     rs1_data, rs2_data, imm;
    logic                  alu_src, uses_rs2;
    logic [3:0]            aluc;
    logic                  rw, mr, mw;
    logic                  em_we;
    logic [REG_ADDR_W-1:0] em_rd;
    logic [DATA_W-1:0]     em_res;
    logic                  mw_we;
    logic [REG_ADDR_W-1:0] mw_rd;
    logic [DATA_W-1:0]     mw_res;
  } stim_t;

  // Contents of the EX slot as the instruction-level model sees it.
  typedef struct {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic [DATA_W-1:0]     d1, d2, imm;
    logic                  alu_src;
    logic [3:0]            aluc;
    logic                  rw, mr, mw;
  } slot_t;

  logic                  clk = 1'b0;
  logic                  reset, stall, flush, id_valid;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic [DATA_W-1:0]     id_rs1_data, id_rs2_data, id_imm;
  logic                  id_alu_src, id_uses_rs2;
  logic [3:0]            id_alu_control;
  logic                  id_reg_write, id_mem_read, id_mem_write;
  logic                  exmem_reg_write, memwb_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd, memwb_rd;
  logic [DATA_W-1:0]     exmem_result, memwb_result;
  logic [DATA_W-1:0]     data1, data2, ex_store_data;
  logic [3:0]            ALU_control;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

  logic [35:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  slot_t       model;

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_uses_rs2(id_uses_rs2), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data1(data1), .data2(data2), .ALU_control(ALU_control), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_hazard(load_use_hazard)
  );

  // Youngest pending writer to a non-zero register supplies the value.
  function automatic logic [DATA_W-1:0] ref_operand(input logic [REG_ADDR_W-1:0] rs,
                                                    input logic [DATA_W-1:0] rf,
                                                    input stim_t s);
    logic                  we[2];
    logic [REG_ADDR_W-1:0] wd[2];
    logic [DATA_W-1:0]     wv[2];
    we[0] = s.em_we; wd[0] = s.em_rd; wv[0] = s.em_res;
    we[1] = s.mw_we; wd[1] = s.mw_rd; wv[1] = s.mw_res;
    if (rs == 0) return rf;
    for (int k = 0; k < 2; k++)
      if (we[k] && wd[k] == rs) return wv[k];
    return rf;
  endfunction

  function automatic slot_t empty_slot();
    slot_t z;
    z.valid = 0; z.rs1 = 0; z.rs2 = 0; z.rd = 0; z.d1 = 0; z.d2 = 0; z.imm = 0;
    z.alu_src = 0; z.aluc = 0; z.rw = 0; z.mr = 0; z.mw = 0;
    return z;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.reset = 0; s.stall = 0; s.flush = 0; s.id_valid = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.rs1_data = 0; s.rs2_data = 0; s.imm = 0;
    s.alu_src = 0; s.uses_rs2 = 0; s.aluc = 0; s.rw = 0; s.mr = 0; s.mw = 0;
    s.em_we = 0; s.em_rd = 0; s.em_res = 0; s.mw_we = 0; s.mw_rd = 0; s.mw_res = 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset = s.reset; stall = s.stall; flush = s.flush; id_valid = s.id_valid;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_rs1_data = s.rs1_data; id_rs2_data = s.rs2_data; id_imm = s.imm;
    id_alu_src = s.alu_src; id_uses_rs2 = s.uses_rs2; id_alu_control = s.aluc;
    id_reg_write = s.rw; id_mem_read = s.mr; id_mem_write = s.mw;
    exmem_reg_write = s.em_we; exmem_rd = s.em_rd; exmem_result = s.em_res;
    memwb_reg_write = s.mw_we; memwb_rd = s.mw_rd; memwb_result = s.mw_res;
  endtask

  // One cycle: drive after the edge, predict this cycle's outputs, then
  // advance the model to what the next edge should leave in the slot.
  task automatic step(input stim_t s, input string name);
    logic [DATA_W-1:0] f1, f2;
    logic              hz;
    @(posedge clk);
    #1;
    apply(s);
    if (s.reset) model = empty_slot();
    f1 = ref_operand(model.rs1, model.d1, s);
    f2 = ref_operand(model.rs2, model.d2, s);
    hz = model.valid && model.mr && model.rd != 0 && s.id_valid &&
         (model.rd == s.rs1 || (s.uses_rs2 && model.rd == s.rs2));
    exp_q.push_back({f1, (model.alu_src ? model.imm : f2), model.aluc, f2, model.rd,
                     model.valid, model.rw, model.mr, model.mw, hz});
    name_q.push_back(name);
    if (s.reset) begin
      model = empty_slot();
    end else if (s.flush || !s.stall) begin
      model.rs1 = s.rs1; model.rs2 = s.rs2; model.rd = s.rd;
      model.d1 = s.rs1_data; model.d2 = s.rs2_data; model.imm = s.imm;
      model.alu_src = s.alu_src;
      model.valid = s.flush ? 1'b0 : s.id_valid;
      model.aluc  = s.flush ? 4'b0000 : s.aluc;
      model.rw    = s.flush ? 1'b0 : s.rw;
      model.mr    = s.flush ? 1'b0 : s.mr;
      model.mw    = s.flush ? 1'b0 : s.mw;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [35:0] e, a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {data1, data2, ALU_control, ex_store_data, ex_rd,
            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got d1=%h d2=%h aluc=%h st=%h rd=%h v/rw/mr/mw/hz=%b, want d1=%h d2=%h aluc=%h st=%h rd=%h v/rw/mr/mw/hz=%b",
                 nm, a[35:28], a[27:20], a[19:16], a[15:8], a[7:5], a[4:0],
                 e[35:28], e[27:20], e[19:16], e[15:8], e[7:5], e[4:0]);
      end
    end
  end

  initial begin
    stim_t s;
    model = empty_slot();
    s = idle();
    s.reset = 1;
    apply(s);

    step(s, "reset_hold");
    step(s, "reset_hold2");

    s = idle(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 2; s.rd = 4;
    s.rs1_data = 8'd5; s.rs2_data = 8'd3; s.aluc = 4'b0010; s.rw = 1;
    step(s, "load_A");
    s = idle(); s.id_valid = 1; s.rs1 = 2; s.rs2 = 5; s.rd = 6; s.rs1_data = 8'h09;
    s.rs2_data = 8'h0E; s.aluc = 4'b0110; s.rw = 1;
    step(s, "A_in_ex");
    s.stall = 1; s.em_we = 1; s.em_rd = 2; s.em_res = 8'h7F;
    step(s, "exmem_fwd");
    s = idle(); s.id_valid = 1; s.rs1 = 0; s.rs2 = 3; s.rs1_data = 8'h21; s.rs2_data = 8'h44;
    s.alu_src = 1; s.imm = 8'hFC; s.aluc = 4'b0010; s.rw = 1;
    s.em_we = 1; s.em_rd = 2; s.em_res = 8'h7F; s.mw_we = 1; s.mw_rd = 2; s.mw_res = 8'h11;
    step(s, "exmem_beats_memwb");
    s = idle(); s.id_valid = 1; s.rd = 3; s.rs1 = 1; s.mr = 1; s.rw = 1; s.aluc = 4'b0010;
    s.em_we = 1; s.em_rd = 0; s.em_res = 8'hAA; s.mw_we = 1; s.mw_rd = 3; s.mw_res = 8'h33;
    step(s, "x0_and_imm");
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 3; s.uses_rs2 = 1; s.stall = 1;
    step(s, "load_use_rs2");
    s = idle(); s.id_valid = 1; s.rs1 = 4; s.rs2 = 3; s.uses_rs2 = 0; s.stall = 1;
    s.rs1_data = 8'h55;
    step(s, "no_hazard_rs2_unused");
    s = idle(); s.id_valid = 1; s.rs1 = 3; s.rs2 = 1; s.stall = 1; s.rs1_data = 8'h66;
    s.aluc = 4'b1111; s.rw = 1;
    step(s, "stall_hold");
    s.stall = 1; s.flush = 1;
    step(s, "stall_flush");
    s = idle(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 5; s.rs2_data = 8'h10; s.aluc = 4'b0001;
    s.rw = 1; s.mw = 1;
    step(s, "bubble_in_ex");
    s = idle(); s.mw_we = 1; s.mw_rd = 5; s.mw_res = 8'h42;
    step(s, "memwb_only_fwd");
    s = idle(); s.reset = 1; s.em_we = 1; s.em_rd = 0; s.em_res = 8'hEE;
    step(s, "async_reset_midstream");
    s = idle();
    step(s, "reset_release");

    for (int i = 0; i < 400; i++) begin
      s.reset    = ($urandom_range(0, 49) == 0);
      s.stall    = ($urandom_range(0, 4) == 0);
      s.flush    = ($urandom_range(0, 7) == 0);
      s.id_valid = $urandom_range(0, 1);
      s.rs1 = REG_ADDR_W'($urandom_range(0, 7));
      s.rs2 = REG_ADDR_W'($urandom_range(0, 7));
      s.rd  = REG_ADDR_W'($urandom_range(0, 7));
      s.rs1_data = DATA_W'($urandom); s.rs2_data = DATA_W'($urandom); s.imm = DATA_W'($urandom);
      s.alu_src = $urandom_range(0, 1); s.uses_rs2 = $urandom_range(0, 1);
      s.aluc = 4'($urandom); s.rw = $urandom_range(0, 1);
      s.mr = $urandom_range(0, 1); s.mw = $urandom_range(0, 1);
      s.em_we = $urandom_range(0, 1); s.em_rd = REG_ADDR_W'($urandom_range(0, 7));
      s.em_res = DATA_W'($urandom);
      s.mw_we = $urandom_range(0, 1); s.mw_rd = REG_ADDR_W'($urandom_range(0, 7));
      s.mw_res = DATA_W'($urandom);
      step(s, "random");
    end

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the 8-bit pipeline, with operand forwarding. It sits directly upstream of the ALU and drives its data1, data2 and ALU_control inputs.
- Latches decoded instruction fields from ID and selects forwarded results from EX/MEM and MEM/WB.
- Detects load-use hazards so the hazard controller can stall IF/ID.

Parameters:
- DATA_W, 8, operand/result width.
- REG_ADDR_W, 3, register index width (8 registers; x0 hardwired zero).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble on the next edge.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source register indices.
- id_rd  in  REG_ADDR_W  destination index.
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_alu_src  in  1  1: data2 = immediate.
- id_uses_rs2  in  1  instruction reads rs2 (R-type/store/branch).
- id_alu_control  in  4  ALU opcode.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- exmem_reg_write  in  1  EX/MEM writeback enable.
- exmem_rd  in  REG_ADDR_W  EX/MEM destination.
- exmem_result  in  DATA_W  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB writeback enable.
- memwb_rd  in  REG_ADDR_W  MEM/WB destination.
- memwb_result  in  DATA_W  MEM/WB result.
- data1  out  DATA_W  ALU operand A.
- data2  out  DATA_W  ALU operand B.
- ALU_control  out  4  ALU opcode.
- ex_store_data  out  DATA_W  forwarded rs2 value, used by stores.
- ex_rd  out  REG_ADDR_W  registered rd.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls.
- load_use_hazard  out  1  combinational stall request.

Behaviour:
- Registered fields: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_control, reg_write, mem_read, mem_write.
- Reset (async, immediate):
  - All registered fields are 0, so ALU_control=4'b0000 and ex_valid=0.
  - data1/data2/ex_store_data therefore read 0 unless forwarding matches.
  - Forwarding cannot match while reset is held: registered rs1=rs2=0 (x0).
- Edge priority: reset > flush > stall > load.
  - flush: valid, reg_write, mem_read and mem_write cleared. Data fields may take the ID values. ALU_control=4'b0000.
  - stall (no flush): every register holds.
  - Otherwise all ID inputs are captured. Latency is 1 cycle from ID inputs to registered outputs.
- Flush and stall asserted together: flush wins and the bubble is inserted.
- Forwarding, combinational on the registered rs1 and, identically, rs2:
  - If exmem_reg_write && exmem_rd != 0 && exmem_rd == rs: use exmem_result.
  - Else if memwb_reg_write && memwb_rd != 0 && memwb_rd == rs: use memwb_result.
  - Else use the registered read data.
  - When both stages match, EX/MEM wins because it is younger.
  - x0 is never forwarded.
- data1 = fwd_rs1.
- data2 = alu_src ? imm : fwd_rs2.
- ex_store_data = fwd_rs2, regardless of alu_src.
- Forwarding is active even when ex_valid=0; the result is harmless because the bubble's controls are zero.
- load_use_hazard = ex_valid && ex_mem_read && ex_rd != 0 && id_valid && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2)).
  - The external controller responds with stall on IF/ID and flush on this stage. This block does not self-stall.
- Widths: all data paths are DATA_W. There is no arithmetic in this block.

Test Plan:
- Reset and bubble:
  - Assert reset mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
  - Release reset, then id_valid=1, alu_control=0010, rs1_data=5, rs2_data=3, alu_src=0 -> next cycle data1=5, data2=3, ALU_control=0010, ex_valid=1.
- EX/MEM forwarding:
  - Registered rs1=2, exmem_reg_write=1, exmem_rd=2, exmem_result=0x7F -> data1=0x7F.
  - Same setup with memwb_rd=2, memwb_result=0x11 also matching -> data1 still 0x7F (EX/MEM wins).
- x0 and immediate:
  - rs1=0 with exmem_rd=0, exmem_reg_write=1, result 0xAA -> data1 = registered rs1_data.
  - alu_src=1, imm=0xFC, rs2 forwarded 0x33 -> data2=0xFC, ex_store_data=0x33.
- Load-use hazard:
  - EX holds a load with rd=3; ID has rs2=3 and id_uses_rs2=1 -> load_use_hazard=1.
  - Same with id_uses_rs2=0 and rs1=4 -> load_use_hazard=0.
- Stall/flush:
  - stall=1 for 2 cycles while the ID inputs change -> outputs unchanged.
  - stall=1 and flush=1 together -> next cycle ex_valid=0, reg_write=0, mem_read=0, mem_write=0, ALU_control=0000.
- MEM/WB-only forwarding:
  - rs2=5, memwb_rd=5, memwb_reg_write=1, memwb_result=0x42, exmem_reg_write=0, alu_src=0 -> data2=0x42.
